// File: rtl/tlb_miss_arbiter_pkg.sv
// Shared types for the TLB miss arbiter: FSM states, walk owner and the
// architectural width from which the virtual address width is derived.
package tlb_miss_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_ITLB = 1'b0,
        OWNER_DTLB = 1'b1
    } owner_e;

endpackage

// File: rtl/tlb_miss_arbiter.sv
// Arbitrates ITLB/DTLB misses onto a single page-table walker, one walk at a
// time, with round-robin on ties and flush handling that drains in-flight walks.
module tlb_miss_arbiter
    import tlb_miss_arbiter_pkg::*;
#(
    parameter int VLEN  = XLEN,
    parameter int PTE_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             itlb_miss_i,
    input  logic [VLEN-1:0]  itlb_vaddr_i,
    output logic             itlb_gnt_o,
    output logic             itlb_done_o,
    input  logic             dtlb_miss_i,
    input  logic [VLEN-1:0]  dtlb_vaddr_i,
    input  logic             dtlb_is_store_i,
    output logic             dtlb_gnt_o,
    output logic             dtlb_done_o,
    output logic             ptw_req_o,
    output logic [VLEN-1:0]  ptw_vaddr_o,
    output logic             ptw_is_instr_o,
    output logic             ptw_is_store_o,
    input  logic             ptw_ready_i,
    input  logic             ptw_valid_i,
    input  logic [PTE_W-1:0] ptw_pte_i,
    input  logic             ptw_err_i,
    output logic [PTE_W-1:0] resp_pte_o,
    output logic             resp_err_o,
    output logic             busy_o
);

    arb_state_e       r_state;
    owner_e           r_owner;
    owner_e           r_last_owner;
    logic [VLEN-1:0]  r_vaddr;
    logic             r_is_instr;
    logic             r_is_store;
    logic             r_ptw_req;
    logic [PTE_W-1:0] r_resp_pte;
    logic             r_resp_err;
    logic             r_itlb_done;
    logic             r_dtlb_done;

    logic w_can_grant;
    logic w_pick_dtlb;
    logic w_grant_i;
    logic w_grant_d;

    // The done cycle is an IDLE cycle but must not start a new walk.
    assign w_can_grant = rst_ni && (r_state == ST_IDLE) && !flush_i
                         && !(r_itlb_done || r_dtlb_done);
    assign w_pick_dtlb = dtlb_miss_i && (!itlb_miss_i || (r_last_owner == OWNER_ITLB));
    assign w_grant_i   = w_can_grant && itlb_miss_i && !w_pick_dtlb;
    assign w_grant_d   = w_can_grant && w_pick_dtlb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWNER_ITLB;
            r_last_owner <= OWNER_ITLB;
            r_vaddr      <= '0;
            r_is_instr   <= 1'b0;
            r_is_store   <= 1'b0;
            r_ptw_req    <= 1'b0;
            r_resp_pte   <= '0;
            r_resp_err   <= 1'b0;
            r_itlb_done  <= 1'b0;
            r_dtlb_done  <= 1'b0;
        end else begin
            r_itlb_done <= 1'b0;
            r_dtlb_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_owner      <= w_grant_d ? OWNER_DTLB : OWNER_ITLB;
                        r_last_owner <= w_grant_d ? OWNER_DTLB : OWNER_ITLB;
                        r_vaddr      <= w_grant_d ? dtlb_vaddr_i : itlb_vaddr_i;
                        r_is_instr   <= w_grant_i;
                        r_is_store   <= w_grant_d && dtlb_is_store_i;
                        r_ptw_req    <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A walk accepted in the flush cycle still returns a result that must be drained.
                    if (flush_i) begin
                        r_ptw_req <= 1'b0;
                        r_state   <= ptw_ready_i ? ST_DRAIN : ST_IDLE;
                    end else if (ptw_ready_i) begin
                        r_ptw_req <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ptw_valid_i) begin
                        if (!flush_i) begin
                            r_resp_pte  <= ptw_pte_i;
                            r_resp_err  <= ptw_err_i;
                            r_itlb_done <= (r_owner == OWNER_ITLB);
                            r_dtlb_done <= (r_owner == OWNER_DTLB);
                        end
                        r_state <= ST_IDLE;
                    end else if (flush_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ptw_valid_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign itlb_gnt_o     = w_grant_i;
    assign dtlb_gnt_o     = w_grant_d;
    assign itlb_done_o    = r_itlb_done;
    assign dtlb_done_o    = r_dtlb_done;
    assign ptw_req_o      = r_ptw_req;
    assign ptw_vaddr_o    = r_vaddr;
    assign ptw_is_instr_o = r_is_instr;
    assign ptw_is_store_o = r_is_store;
    assign resp_pte_o     = r_resp_pte;
    assign resp_err_o     = r_resp_err;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: doc/tlb_miss_arbiter.md
TLB_MISS_ARBITER -- requirements
Module: tlb_miss_arbiter

Interface
REQ-001 SHALL have parameter VLEN, default 32, virtual address width.
REQ-002 SHALL have parameter PTE_W, default 32, PTE width (Sv32).
REQ-003 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  abort current and pending translation.
REQ-006 SHALL have ports itlb_miss_i in 1, itlb_vaddr_i in VLEN: ITLB miss request and address.
REQ-007 SHALL have ports itlb_gnt_o out 1, itlb_done_o out 1: ITLB request accepted; ITLB result valid.
REQ-008 SHALL have ports dtlb_miss_i in 1, dtlb_vaddr_i in VLEN, dtlb_is_store_i in 1: DTLB request, address, store access.
REQ-009 SHALL have ports dtlb_gnt_o out 1, dtlb_done_o out 1: DTLB accepted; DTLB result valid.
REQ-010 SHALL have ports ptw_req_o out 1, ptw_vaddr_o out VLEN, ptw_is_instr_o out 1, ptw_is_store_o out 1, ptw_ready_i in 1: walk request handshake.
REQ-011 SHALL have ports ptw_valid_i in 1, ptw_pte_i in PTE_W, ptw_err_i in 1: walk result.
REQ-012 SHALL have ports resp_pte_o out PTE_W, resp_err_o out 1, busy_o out 1: shared result; arbiter not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN.
REQ-014 IDLE, flush_i low, any miss high: SHALL pulse the winner's gnt_o combinationally that cycle, latch vaddr/is_instr/is_store, go ISSUE.
REQ-015 Both misses high in IDLE: SHALL grant the requester not granted last (round-robin); last-grant pointer resets to ITLB, so DTLB wins first tie.
REQ-016 Single miss high: SHALL grant it regardless of pointer; pointer updates on every grant.
REQ-017 ISSUE: ptw_req_o SHALL be high with latched fields stable; on ptw_ready_i high go WAIT.
REQ-018 Grant-to-ptw_req_o latency SHALL be exactly 1 cycle.
REQ-019 WAIT: on ptw_valid_i, SHALL register ptw_pte_i/ptw_err_i into resp_pte_o/resp_err_o and pulse the owner's done_o for exactly 1 cycle next cycle; return IDLE.
REQ-020 A new grant SHALL NOT occur in the cycle done_o is high (minimum 1 IDLE cycle between walks).
REQ-021 resp_pte_o/resp_err_o SHALL hold last value until next result.
REQ-022 flush_i in IDLE: no grant that cycle.
REQ-023 flush_i in ISSUE: ptw_req_o SHALL drop next cycle, go IDLE, no done_o.
REQ-024 flush_i in WAIT without ptw_valid_i: go DRAIN; DRAIN waits for ptw_valid_i, discards it, goes IDLE, no done_o.
REQ-025 flush_i and ptw_valid_i together in WAIT: result discarded, go IDLE, no done_o.
REQ-026 flush_i and ptw_ready_i together in ISSUE: treat as accepted, go DRAIN.
REQ-027 ptw_valid_i in IDLE or ISSUE SHALL be ignored.
REQ-028 busy_o SHALL be high in ISSUE, WAIT, DRAIN.
REQ-029 Requesters SHALL hold miss/vaddr until gnt; arbiter SHALL not retain ungranted requests.

Reset
REQ-030 rst_ni low SHALL force IDLE, pointer=ITLB, all *_o low/zero, asynchronously.
REQ-031 Reset mid-walk SHALL drop the walk; no done_o after release.

Structure
REQ-032 SHALL place state enum and owner enum (ITLB/DTLB) in the shared config/types package; VLEN derives from the XLEN constant.
REQ-033 SHALL be a single module; no sub-modules.

Verification
REQ-034 ITLB only, vaddr 0x8000_1000; ready at +1, valid at +4 with pte 0x2000_00CF -> itlb_gnt_o cycle 0, ptw_req_o cycle 1, itlb_done_o cycle 6 with resp_pte_o 0x2000_00CF.
REQ-035 Both miss after reset, held through 3 walks -> order DTLB, ITLB, DTLB; ptw_is_instr_o 0,1,0.
REQ-036 DTLB store 0x0000_4000 -> ptw_is_store_o 1; ptw_err_i 1 -> dtlb_done_o with resp_err_o 1.
REQ-037 flush_i in WAIT, valid 3 cycles later -> no done_o, busy_o high until that valid, then IDLE.
REQ-038 flush_i in ISSUE with ptw_ready_i low -> ptw_req_o low next cycle, no done_o; flush_i with ptw_valid_i in WAIT -> IDLE, no done_o.
REQ-039 rst_ni low during WAIT -> outputs zero immediately; late ptw_valid_i ignored.
